// File: rtl/mem_stage_pkg.sv
// Shared types for the stack/memory unit: opcodes, FSM state,
// response source select and default widths.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    PUSH  = 3'd3,
    POP   = 3'd4,
    PUSH2 = 3'd5,
    POP2  = 3'd6
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_SECOND
  } state_e;

  typedef enum logic [1:0] {
    RSP_ZERO,
    RSP_WORD,
    RSP_DWORD
  } rsp_sel_e;

endpackage

// File: rtl/data_memory.sv
// Single-port word memory: synchronous write, registered read.
// Contents are never reset.
module data_memory #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_mem_unit.sv
// Load/store + hardware stack unit over one single-port memory.
// Define STACK_BOUNDS_CHECK_EN to enable push/pop bounds errors.
module stack_mem_unit
  import mem_stage_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   sp
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] sp_inc, sp_dec;

  logic is_load, is_store, is_push;
  logic is_pop, is_push2, is_pop2;
  logic acc, err, go_second;

  logic [DATA_W-1:0] wlo, whi;
  logic              pend_push2_q;
  logic [DATA_W-1:0] pend_lo_q, low_q;

  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic                rsp_valid_q;
  rsp_sel_e            rsp_sel_q;
  logic [2*DATA_W-1:0] hold_q, rdata_now;

  assign is_load  = req_op == LOAD;
  assign is_store = req_op == STORE;
  assign is_push  = req_op == PUSH;
  assign is_pop   = req_op == POP;
  assign is_push2 = req_op == PUSH2;
  assign is_pop2  = req_op == POP2;

  assign wlo    = req_wdata[DATA_W-1:0];
  assign whi    = req_wdata[2*DATA_W-1:DATA_W];
  assign sp_inc = sp_q + ADDR_W'(1);
  assign sp_dec = sp_q - ADDR_W'(1);

  assign acc = req_valid && !rst
            && state_q == S_IDLE;

`ifdef STACK_BOUNDS_CHECK_EN
  logic [ADDR_W-1:0] depth;
  assign depth = SP_RESET - sp_q;
  assign err = (is_push  && sp_q  < ADDR_W'(1))
            || (is_push2 && sp_q  < ADDR_W'(2))
            || (is_pop   && depth < ADDR_W'(1))
            || (is_pop2  && depth < ADDR_W'(2));
`else
  assign err = 1'b0;
`endif

  assign go_second = acc && !err
                  && (is_push2 || is_pop2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go_second) state_d = S_SECOND;
      S_SECOND: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst || state_q == S_IDLE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = wlo;
    sp_d      = sp_q;
    if (acc && !err) begin
      unique case (1'b1)
        is_load: mem_en = 1'b1;
        is_store: begin
          mem_en = 1'b1;
          mem_we = 1'b1;
        end
        is_push, is_push2: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = sp_q;
          mem_wdata = is_push2 ? whi : wlo;
          sp_d      = sp_dec;
        end
        is_pop, is_pop2: begin
          mem_en   = 1'b1;
          mem_addr = sp_inc;
          sp_d     = sp_inc;
        end
        default: ;
      endcase
    end else if (state_q == S_SECOND && !rst) begin
      // Second word of PUSH2/POP2 works on the already-moved sp
      mem_en    = 1'b1;
      mem_we    = pend_push2_q;
      mem_addr  = pend_push2_q ? sp_q : sp_inc;
      mem_wdata = pend_lo_q;
      sp_d      = pend_push2_q ? sp_dec : sp_inc;
    end
  end

  data_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q         <= SP_RESET;
      rsp_valid_q  <= 1'b0;
      rsp_sel_q    <= RSP_ZERO;
      hold_q       <= '0;
      pend_push2_q <= 1'b0;
      pend_lo_q    <= '0;
      low_q        <= '0;
    end else begin
      sp_q        <= sp_d;
      rsp_valid_q <= (acc && !go_second)
                  || state_q == S_SECOND;
      if (rsp_valid_q) begin
        hold_q <= rdata_now;
      end
      if (acc) begin
        pend_push2_q <= is_push2;
        pend_lo_q    <= wlo;
        rsp_sel_q    <= (!err && (is_load || is_pop))
                      ? RSP_WORD : RSP_ZERO;
      end else if (state_q == S_SECOND) begin
        low_q     <= mem_rdata;
        rsp_sel_q <= pend_push2_q ? RSP_ZERO : RSP_DWORD;
      end
    end
  end

  always_comb begin
    rdata_now = '0;
    unique case (rsp_sel_q)
      RSP_WORD:  rdata_now = {{DATA_W{1'b0}}, mem_rdata};
      RSP_DWORD: rdata_now = {mem_rdata, low_q};
      default:   rdata_now = '0;
    endcase
  end

  assign rsp_valid = rsp_valid_q && !rst;
  assign sp        = rst ? SP_RESET : sp_q;
  assign rsp_rdata = rst         ? '0
                   : rsp_valid_q ? rdata_now
                   : hold_q;

`ifdef STACK_BOUNDS_CHECK_EN
  logic rsp_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= acc && err;
    end
  end
  assign rsp_err = rsp_err_q && !rst;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_mem_unit.sv
// Bench for stack_mem_unit: reference model plus directed vectors.
module tb_stack_mem_unit;

  localparam bit [2:0] O_NOP   = 3'd0;
  localparam bit [2:0] O_LOAD  = 3'd1;
  localparam bit [2:0] O_STORE = 3'd2;
  localparam bit [2:0] O_PUSH  = 3'd3;
  localparam bit [2:0] O_POP   = 3'd4;
  localparam bit [2:0] O_PUSH2 = 3'd5;
  localparam bit [2:0] O_POP2  = 3'd6;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [10:0] sp;

  int errors = 0;
  int checks = 0;

  stack_mem_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sp        (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: memory array, stack pointer, pending 2nd word
  bit [15:0] mm [2048];
  bit [10:0] m_sp = 11'h7FF;
  bit        m_busy = 0;
  bit        m_push2 = 0;
  bit [15:0] m_lo = 0;
  bit [10:0] nx;
  bit        e_valid = 0;
  bit        e_err = 0;
  bit [31:0] e_data = 0;
  bit [31:0] e_last = 0;

  function automatic bit bad(input bit grow, input int n);
`ifdef STACK_BOUNDS_CHECK_EN
    if (grow) return int'(m_sp) < n;
    return (2047 - int'(m_sp)) < n;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (e_valid) e_last = e_data;
    e_valid = 0;
    e_err   = 0;
    e_data  = 0;
    if (rst) begin
      m_sp   = 11'h7FF;
      m_busy = 0;
      e_last = 0;
    end else if (m_busy) begin
      m_busy  = 0;
      e_valid = 1;
      if (m_push2) begin
        mm[m_sp] = m_lo;
        m_sp = m_sp - 11'd1;
      end else begin
        nx = m_sp + 11'd1;
        e_data = {mm[nx], m_lo};
        m_sp = nx;
      end
    end else if (req_valid) begin
      e_valid = 1;
      case (req_op)
        O_LOAD: e_data = {16'h0, mm[req_addr]};
        O_STORE: mm[req_addr] = req_wdata[15:0];
        O_PUSH:
          if (bad(1, 1)) e_err = 1;
          else begin
            mm[m_sp] = req_wdata[15:0];
            m_sp = m_sp - 11'd1;
          end
        O_POP:
          if (bad(0, 1)) e_err = 1;
          else begin
            nx = m_sp + 11'd1;
            e_data = {16'h0, mm[nx]};
            m_sp = nx;
          end
        O_PUSH2:
          if (bad(1, 2)) e_err = 1;
          else begin
            mm[m_sp] = req_wdata[31:16];
            m_sp = m_sp - 11'd1;
            m_lo = req_wdata[15:0];
            m_push2 = 1;
            m_busy = 1;
            e_valid = 0;
          end
        O_POP2:
          if (bad(0, 2)) e_err = 1;
          else begin
            nx = m_sp + 11'd1;
            m_lo = mm[nx];
            m_sp = nx;
            m_push2 = 0;
            m_busy = 1;
            e_valid = 0;
          end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_sp", 32'(sp), 32'h7FF);
    end else begin
      chk("ready", 32'(req_ready), 32'(!m_busy));
      chk("valid", 32'(rsp_valid), 32'(e_valid));
      chk("err", 32'(rsp_err), 32'(e_err));
      chk("rdata", rsp_rdata, e_valid ? e_data : e_last);
      chk("sp", 32'(sp), 32'(m_sp));
    end
  end

  task automatic step(input bit v, input bit [2:0] op,
                      input bit [10:0] a,
                      input bit [31:0] wd, input bit r);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    rst       = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(0, O_NOP, 11'h0, 32'h0, 0);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_op = 0;
    req_addr = 0; req_wdata = 0;
    step(0, O_NOP, 0, 0, 1);
    step(0, O_NOP, 0, 0, 1);
    chk("lit_reset_sp", 32'(sp), 32'h7FF);
    chk("lit_reset_ready", 32'(req_ready), 32'd1);
    chk("lit_reset_valid", 32'(rsp_valid), 32'd0);

    step(1, O_STORE, 11'h000, 32'h0BAD, 0);
    chk("lit_store0_valid", 32'(rsp_valid), 32'd1);

    step(1, O_PUSH, 0, 32'h1234, 0);
    chk("lit_push_valid", 32'(rsp_valid), 32'd1);
    chk("lit_push_err", 32'(rsp_err), 32'd0);
    chk("lit_push_sp", 32'(sp), 32'h7FE);
    chk("lit_model_mem", 32'(mm[11'h7FF]), 32'h1234);
    step(1, O_POP, 0, 0, 0);
    chk("lit_pop_rdata", rsp_rdata, 32'h1234);
    chk("lit_pop_sp", 32'(sp), 32'h7FF);

    step(1, O_PUSH2, 0, 32'hAAAA5555, 0);
    chk("lit_push2_ready", 32'(req_ready), 32'd0);
    chk("lit_push2_novalid", 32'(rsp_valid), 32'd0);
    idle();
    chk("lit_push2_valid", 32'(rsp_valid), 32'd1);
    chk("lit_push2_sp", 32'(sp), 32'h7FD);
    step(1, O_POP2, 0, 0, 0);
    chk("lit_pop2_ready", 32'(req_ready), 32'd0);
    idle();
    chk("lit_pop2_rdata", rsp_rdata, 32'hAAAA5555);
    chk("lit_pop2_sp", 32'(sp), 32'h7FF);

    step(1, O_STORE, 11'h010, 32'h00F0, 0);
    step(1, O_LOAD, 11'h010, 0, 0);
    chk("lit_load_rdata", rsp_rdata, 32'h000000F0);
    idle();
    chk("lit_hold_rdata", rsp_rdata, 32'h000000F0);
    step(1, O_NOP, 0, 32'hFFFF, 0);
    chk("lit_nop_rdata", rsp_rdata, 32'h0);
    step(1, 3'd7, 0, 32'hFFFF, 0);
    chk("lit_op7_valid", 32'(rsp_valid), 32'd1);

    step(1, O_PUSH2, 0, 32'h11112222, 0);
    step(0, O_NOP, 0, 0, 1);
    chk("lit_abort_novalid", 32'(rsp_valid), 32'd0);
    chk("lit_abort_sp", 32'(sp), 32'h7FF);
    idle();
    chk("lit_abort_ready", 32'(req_ready), 32'd1);
    step(1, O_LOAD, 11'h7FE, 0, 0);
    chk("lit_abort_lowkept", rsp_rdata, 32'h5555);
    step(1, O_LOAD, 11'h7FF, 0, 0);
    chk("lit_abort_high", rsp_rdata, 32'h1111);

    step(1, O_PUSH2, 0, 32'hCAFE0001, 0);
    chk("lit_b2b_sp1", 32'(sp), 32'h7FE);
    step(1, O_PUSH2, 0, 32'hCAFE0001, 0);
    chk("lit_b2b_sp2", 32'(sp), 32'h7FD);
    step(1, O_PUSH2, 0, 32'hCAFE0001, 0);
    chk("lit_b2b_sp3", 32'(sp), 32'h7FC);
    idle();
    chk("lit_b2b_sp4", 32'(sp), 32'h7FB);
    idle();

    step(0, O_NOP, 0, 0, 1);
    idle();
    step(1, O_POP, 0, 0, 0);
`ifdef STACK_BOUNDS_CHECK_EN
    chk("lit_under_err", 32'(rsp_err), 32'd1);
    chk("lit_under_sp", 32'(sp), 32'h7FF);
`else
    chk("lit_wrap_err", 32'(rsp_err), 32'd0);
    chk("lit_wrap_sp", 32'(sp), 32'h000);
    chk("lit_wrap_rdata", rsp_rdata, 32'h0BAD);
`endif

    step(0, O_NOP, 0, 0, 1);
    step(1, O_PUSH, 0, 32'h7777, 0);
    step(1, O_POP2, 0, 0, 0);
`ifdef STACK_BOUNDS_CHECK_EN
    chk("lit_pop2u_err", 32'(rsp_err), 32'd1);
    chk("lit_pop2u_sp", 32'(sp), 32'h7FE);
`else
    idle();
    chk("lit_pop2w_rdata", rsp_rdata, 32'h0BAD7777);
    chk("lit_pop2w_sp", 32'(sp), 32'h000);
`endif
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
